// File: rtl/blob_motion_ctrl.sv
// Per-frame sprite position controller: steps (x, y) by (vx, vy) at the start of
// vertical blanking, bouncing off the screen edges, with a valid/ready reconfiguration port.
module blob_motion_ctrl #(
    parameter int SCREEN_W = 1024,
    parameter int V_ACTIVE = 768,
    parameter int WIDTH    = 110,
    parameter int HEIGHT   = 59,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int VX0      = 2,
    parameter int VY0      = 1
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_vx,
    input  logic [3:0]  cfg_vy,
    input  logic        cfg_load_pos,
    input  logic [10:0] cfg_x,
    input  logic [9:0]  cfg_y,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_tick,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, DONE} state_t;

    localparam logic [10:0] X_LIM   = 11'(SCREEN_W - WIDTH);
    localparam logic [9:0]  Y_LIM   = 10'(V_ACTIVE - HEIGHT);
    localparam logic [9:0]  V_TRIG  = 10'(V_ACTIVE);
    localparam logic [10:0] X_RST   = 11'(X0);
    localparam logic [9:0]  Y_RST   = 10'(Y0);
    localparam logic [3:0]  VX_RST  = 4'(VX0);
    localparam logic [3:0]  VY_RST  = 4'(VY0);

    // cfg: valid/ready handshake; a transfer happens on a rising edge where
    // cfg_valid && cfg_ready, and cfg_ready is high only while the FSM is IDLE.

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [3:0]  vx_q, vx_d;
    logic [3:0]  vy_q, vy_d;
    logic        frame_tick_q, frame_tick_d;
    logic        bounce_x_q, bounce_x_d;
    logic        bounce_y_q, bounce_y_d;
    logic        pend_bx_q, pend_bx_d;
    logic [12:0] nx;
    logic [11:0] ny;

    // -8 has no positive counterpart in 4 bits, so it is folded to -7.
    function automatic logic [3:0] clamp_v(input logic [3:0] v);
        return (v == 4'b1000) ? 4'b1001 : v;
    endfunction

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        pend_bx_d    = pend_bx_q;
        frame_tick_d = 1'b0;
        bounce_x_d   = 1'b0;
        bounce_y_d   = 1'b0;
        nx = {2'b00, x_q} + {{9{vx_q[3]}}, vx_q};
        ny = {2'b00, y_q} + {{8{vy_q[3]}}, vy_q};
        case (state_q)
            IDLE: begin
                pend_bx_d = 1'b0;
                if (cfg_valid) begin
                    vx_d = clamp_v(cfg_vx);
                    vy_d = clamp_v(cfg_vy);
                    if (cfg_load_pos) begin
                        x_d = (cfg_x > X_LIM) ? X_LIM : cfg_x;
                        y_d = (cfg_y > Y_LIM) ? Y_LIM : cfg_y;
                    end
                end
                if (hcount == 11'd0 && vcount == V_TRIG) state_d = UPD_X;
            end
            UPD_X: begin
                if (enable) begin
                    if (nx[12]) begin
                        x_d = 11'd0;
                        vx_d = -vx_q;
                        pend_bx_d = 1'b1;
                    end else if (nx > {2'b00, X_LIM}) begin
                        x_d = X_LIM;
                        vx_d = -vx_q;
                        pend_bx_d = 1'b1;
                    end else begin
                        x_d = nx[10:0];
                    end
                end
                state_d = UPD_Y;
            end
            UPD_Y: begin
                if (enable) begin
                    if (ny[11]) begin
                        y_d = 10'd0;
                        vy_d = -vy_q;
                        bounce_y_d = 1'b1;
                    end else if (ny > {2'b00, Y_LIM}) begin
                        y_d = Y_LIM;
                        vy_d = -vy_q;
                        bounce_y_d = 1'b1;
                    end else begin
                        y_d = ny[9:0];
                    end
                end
                // Both bounce pulses line up with frame_tick in DONE.
                bounce_x_d   = pend_bx_q;
                frame_tick_d = 1'b1;
                state_d      = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            x_q          <= X_RST;
            y_q          <= Y_RST;
            vx_q         <= VX_RST;
            vy_q         <= VY_RST;
            pend_bx_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            bounce_x_q   <= 1'b0;
            bounce_y_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            pend_bx_q    <= pend_bx_d;
            frame_tick_q <= frame_tick_d;
            bounce_x_q   <= bounce_x_d;
            bounce_y_q   <= bounce_y_d;
        end
    end

    assign cfg_ready  = (state_q == IDLE);
    assign x          = x_q;
    assign y          = y_q;
    assign frame_tick = frame_tick_q;
    assign bounce_x   = bounce_x_q;
    assign bounce_y   = bounce_y_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_blob_motion_ctrl.sv
// Scoreboard bench for blob_motion_ctrl: each frame trigger queues the expected
// position, bounce flags and frame_tick cycle; a negedge monitor checks every tick.
module tb_blob_motion_ctrl;
    localparam int W = 39;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = 11'd5;
    logic [9:0]  vcount = 10'd100;
    logic        enable = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_vx = 4'd0;
    logic [3:0]  cfg_vy = 4'd0;
    logic        cfg_load_pos = 1'b0;
    logic [10:0] cfg_x = 11'd0;
    logic [9:0]  cfg_y = 10'd0;
    logic [10:0] x;
    logic [9:0]  y;
    logic        frame_tick, bounce_x, bounce_y;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    blob_motion_ctrl dut (
        .pixel_clk(clk), .reset_n(rst_n), .hcount(hcount), .vcount(vcount),
        .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_load_pos(cfg_load_pos),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .x(x), .y(y), .frame_tick(frame_tick),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: frame_tick at cycle %0d with nothing expected", cyc);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, int'(e[38:23]));
                    check("x", int'(x), int'(e[22:12]));
                    check("y", int'(y), int'(e[11:2]));
                    check("bounce_x", int'(bounce_x), int'(e[1]));
                    check("bounce_y", int'(bounce_y), int'(e[0]));
                end
            end else if (bounce_x || bounce_y) begin
                checks++;
                errors++;
                $display("FAIL stray_bounce: bx=%0d by=%0d without frame_tick", bounce_x, bounce_y);
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit push, input bit with_cfg, input int ex, input int ey,
                               input bit bx, input bit by);
        @(posedge clk);
        #1;
        hcount = 11'd0;
        vcount = 10'd768;
        if (with_cfg) cfg_valid = 1'b1;
        if (push) exp_q.push_back({16'(cyc + 3), 11'(ex), 10'(ey), bx, by});
        @(posedge clk);
        #1;
        hcount = 11'd5;
        vcount = 10'd100;
        cfg_valid = 1'b0;
    endtask

    task automatic frame(input int ex, input int ey, input bit bx, input bit by);
        start_frame(1'b1, 1'b0, ex, ey, bx, by);
        idle(6);
    endtask

    task automatic set_cfg(input logic [3:0] vx, input logic [3:0] vy, input bit ld,
                           input int px, input int py);
        cfg_vx = vx;
        cfg_vy = vy;
        cfg_load_pos = ld;
        cfg_x = 11'(px);
        cfg_y = 10'(py);
    endtask

    task automatic send_cfg();
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        int waited;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_ready", int'(cfg_ready), 1);

        // defaults: vx=2, vy=1
        frame(2, 1, 0, 0);
        frame(4, 2, 0, 0);
        frame(6, 3, 0, 0);

        // cfg and trigger in the same cycle; right-edge bounce
        set_cfg(4'd7, 4'd1, 1'b1, 910, 3);
        start_frame(1'b1, 1'b1, 914, 4, 1, 0);
        idle(6);
        frame(907, 5, 0, 0);

        // top-edge bounce; vx=0 never bounces
        set_cfg(4'b1101, 4'd0, 1'b1, 500, 1);
        cfg_vx = 4'd0;
        cfg_vy = 4'b1101;
        send_cfg();
        frame(500, 0, 0, 1);
        frame(500, 3, 0, 0);

        // cfg held while busy; -8 folds to -7
        set_cfg(4'b1000, 4'd1, 1'b0, 0, 0);
        start_frame(1'b1, 1'b0, 500, 6, 0, 0);
        cfg_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!cfg_ready && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        check("ready_low_cycles", waited, 3);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        idle(2);
        frame(493, 7, 0, 0);

        // hold with enable=0, clamped position load
        enable = 1'b0;
        frame(493, 7, 0, 0);
        frame(493, 7, 0, 0);
        set_cfg(4'd2, 4'd1, 1'b1, 2000, 1000);
        send_cfg();
        check("clamp_x", int'(x), 914);
        check("clamp_y", int'(y), 709);
        frame(914, 709, 0, 0);
        enable = 1'b1;
        frame(914, 709, 1, 1);

        // reset during UPD_Y
        start_frame(1'b0, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(x), 0);
        check("async_rst_y", int'(y), 0);
        check("async_rst_ready", int'(cfg_ready), 1);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        frame(2, 1, 0, 0);

        idle(4);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/blob_motion_ctrl.md
Name: blob_motion_ctrl

Overview:
- Moves one sprite blob across the screen by producing its top-left position (x, y) once per frame.
- Sits between the video timing generator and a blob renderer. Consumes hcount/vcount and drives the renderer's x/y inputs.
- Updates position only at the start of vertical blanking, so a blob never tears.
- Bounces the blob off screen edges. Velocity and position are reconfigurable through a valid/ready handshake.

Parameters:
- SCREEN_W, 1024, active pixels per line.
- V_ACTIVE, 768, active lines; blanking begins at vcount == V_ACTIVE.
- WIDTH, 110, blob width in pixels.
- HEIGHT, 59, blob height in lines.
- X0, 0, reset x position.
- Y0, 0, reset y position.
- VX0, 2, reset x velocity, signed pixels/frame.
- VY0, 1, reset y velocity, signed lines/frame.

Ports:
- pixel_clk  in  1  pixel clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hcount  in  11  current pixel column.
- vcount  in  10  current line.
- enable  in  1  1 = move each frame; 0 = hold position (cfg still accepted).
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept cfg this cycle.
- cfg_vx  in  4  signed new x velocity.
- cfg_vy  in  4  signed new y velocity.
- cfg_load_pos  in  1  with cfg, also load cfg_x/cfg_y.
- cfg_x  in  11  new x position.
- cfg_y  in  10  new y position.
- x  out  11  blob x to renderer.
- y  out  10  blob y to renderer.
- frame_tick  out  1  one-cycle pulse when a frame update completes.
- bounce_x  out  1  one-cycle pulse; x velocity reversed this frame.
- bounce_y  out  1  one-cycle pulse; y velocity reversed this frame.

Behaviour:
- Reset (async assert, sync release):
  - x=X0, y=Y0, vx=VX0, vy=VY0.
  - frame_tick=0, bounce_x=0, bounce_y=0.
  - State=IDLE; cfg_ready=1.
- State machine states: IDLE, UPD_X, UPD_Y, DONE.
- IDLE -> UPD_X when hcount==0 && vcount==V_ACTIVE. Fires once per frame. Fires regardless of enable.
- UPD_X, one cycle:
  - If enable: nx = x + vx, computed 13-bit signed.
  - If nx < 0: x=0, vx=-vx, bounce_x=1 next cycle.
  - Else if nx > SCREEN_W-WIDTH: x=SCREEN_W-WIDTH, vx=-vx, bounce_x=1.
  - Else: x=nx.
- UPD_Y, one cycle: same rules on y/vy with limit V_ACTIVE-HEIGHT; bounce_y on reversal.
- DONE, one cycle: frame_tick=1, then -> IDLE.
- bounce_x/bounce_y pulse in the same cycle as frame_tick.
- Latency: x valid 2 cycles after the trigger cycle, y valid 3 cycles after, frame_tick high on cycle 3.
- Any velocity of 0 never bounces. enable=0: UPD_X/UPD_Y leave x, y, vx, vy unchanged, no bounce pulses; frame_tick still fires.
- Velocity range is clamped to [-7, +7]:
  - A cfg value of -8 (4'b1000) loads as -7.
  - Negation therefore never overflows.
- cfg handshake:
  - cfg_ready=1 only in IDLE.
  - Transfer occurs when cfg_valid && cfg_ready. vx/vy load on that edge.
  - If cfg_load_pos=1, x/y load in the same transfer, clamped to [0, SCREEN_W-WIDTH] and [0, V_ACTIVE-HEIGHT].
  - cfg_valid held while cfg_ready=0 is not lost; it transfers on first return to IDLE.
  - Transfer and trigger in the same cycle: cfg applies on that edge, the FSM still enters UPD_X, and UPD_X uses the new values.
- Position update with vx=+7 and x already at limit: x stays at limit, vx becomes -7, bounce_x=1.
- Reset asserted mid-update: all state returns to reset values immediately; no frame_tick that frame.
- hcount/vcount jumps that skip the trigger point: no update that frame. Not an error.

Test Plan:
- Reset with defaults, run 3 frames enable=1 -> x=2,4,6 and y=1,2,3 after successive frame_ticks; frame_tick exactly 3 cycles after each (hcount=0, vcount=768).
- cfg vx=+7 with x=910 loaded (cfg_load_pos=1), one frame -> x=914 (limit 1024-110), vx=-7, bounce_x=1 with frame_tick; next frame x=907.
- cfg vy=-3 with y=1 -> y=0, bounce_y=1, vy=+3; next frame y=3.
- cfg_valid asserted during UPD_X -> cfg_ready=0 for 3 cycles, transfer on IDLE return; cfg_vx=4'b1000 loads vx=-7.
- enable=0 for 2 frames -> x/y unchanged, frame_tick pulses twice, no bounce pulses; cfg_x=2000 with cfg_load_pos=1 -> x=914.
- reset_n low during UPD_Y -> x=X0, y=Y0 asynchronously, no frame_tick that frame, normal update next frame.
